// File: rtl/bus_arbiter4_if.sv
// bus_arbiter4_if: request/grant/handshake bundle between four masters, the arbiter and the shared slave.
interface bus_arbiter4_if;
  logic [3:0] req;
  logic       bus_ack;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       bus_req;
  logic [3:0] done;
  logic       timeout;
  modport master (input req, bus_ack, output gnt, sel, bus_req, done, timeout);
  modport slave (output req, bus_ack, input gnt, sel, bus_req, done, timeout);
endinterface

// File: rtl/bus_arbiter4.sv
// bus_arbiter4: four-master round-robin arbiter holding the grant until bus_ack or master abort.
// Optional ARB_TIMEOUT_EN aborts a grant after TIMEOUT BUSY cycles without bus_ack.
module bus_arbiter4 #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W = 8
) (
  input logic clk,
  input logic rstn,
  bus_arbiter4_if.master b
);
  localparam logic [0:0] IDLE = 1'b0, BUSY = 1'b1;
  if (TIMEOUT < 2 || TIMEOUT > 255 || (64'd1 << CNT_W) <= 64'(TIMEOUT)) begin : g_bad_param
    $error("bus_arbiter4: TIMEOUT/CNT_W out of range");
  end
  logic [0:0] state;
  logic [1:0] last, pick, sel;
  logic [3:0] gnt;
  logic       tmo_hit, fin;
  // Scan last+1 .. last+4; iterating backwards lets the nearest requester win.
  always_comb begin
    pick = '0;
    for (int k = 4; k >= 1; k--) if (b.req[last + 2'(k)]) pick = last + 2'(k);
  end
  assign fin = b.bus_ack | ~b.req[sel] | tmo_hit;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      gnt <= '0;
      sel <= '0;
      last <= 2'd3;
    end else if (state == IDLE) begin
      if (|b.req) begin
        state <= BUSY;
        gnt <= 4'd1 << pick;
        sel <= pick;
      end
    end else if (fin) begin
      state <= IDLE;
      gnt <= '0;
      last <= sel;
    end
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic             timeout;
  assign tmo_hit = state == BUSY && cnt == CNT_W'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt <= '0;
      timeout <= 1'b0;
    end else begin
      cnt <= state == IDLE ? '0 : (&cnt ? cnt : cnt + 1'b1);
      timeout <= tmo_hit & ~b.bus_ack & b.req[sel];
    end
  assign b.timeout = timeout;
`else
  assign tmo_hit = 1'b0;
  assign b.timeout = 1'b0;
`endif
  assign b.gnt = gnt;
  assign b.sel = sel;
  assign b.bus_req = state == BUSY;
  assign b.done = gnt & {4{b.bus_ack & (state == BUSY)}};
endmodule

// File: tb/tb_bus_arbiter4.sv
// tb_bus_arbiter4: directed round-robin, abort, reset and timeout vectors for bus_arbiter4.
module tb_bus_arbiter4;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  bus_arbiter4_if bus ();
  bus_arbiter4 #(.TIMEOUT(4), .CNT_W(8)) dut (.clk(clk), .rstn(rstn), .b(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.req = 4'b0000;
    bus.bus_ack = 1'b0;
    step();
    step();
    chk("rst_gnt", bus.gnt, 4'b0000);
    chk("rst_sel", {2'b0, bus.sel}, 4'd0);
    chk("rst_busreq", {3'b0, bus.bus_req}, 4'd0);
    chk("rst_done", bus.done, 4'b0000);
    chk("rst_tmo", {3'b0, bus.timeout}, 4'd0);
    rstn = 1'b1;
    step();
    chk("idle_gnt", bus.gnt, 4'b0000);
    // single request, ack two cycles after grant
    bus.req = 4'b0001;
    step();
    chk("t1_gnt", bus.gnt, 4'b0001);
    chk("t1_sel", {2'b0, bus.sel}, 4'd0);
    chk("t1_busreq", {3'b0, bus.bus_req}, 4'd1);
    step();
    chk("t1_hold", bus.gnt, 4'b0001);
    step();
    bus.bus_ack = 1'b1;
    #1;
    chk("t1_done", bus.done, 4'b0001);
    step();
    bus.bus_ack = 1'b0;
    bus.req = 4'b0000;
    chk("t1_release", bus.gnt, 4'b0000);
    chk("t1_busreq0", {3'b0, bus.bus_req}, 4'd0);
    // fresh reset so master 0 leads, then all four request
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    bus.req = 4'b1111;
    for (int m = 0; m < 4; m++) begin
      step();
      chk("rr_gnt", bus.gnt, 4'(1 << m));
      chk("rr_sel", {2'b0, bus.sel}, 4'(m));
      step();
      bus.bus_ack = 1'b1;
      #1;
      chk("rr_done", bus.done, 4'(1 << m));
      step();
      bus.bus_ack = 1'b0;
      bus.req[m] = 1'b0;
      chk("rr_idle", bus.gnt, 4'b0000);
    end
    // make last=2, then wrap to 0, then re-request serves 2
    bus.req = 4'b0100;
    step();
    chk("w_gnt2", bus.gnt, 4'b0100);
    bus.bus_ack = 1'b1;
    step();
    bus.bus_ack = 1'b0;
    bus.req = 4'b0101;
    step();
    chk("w_gnt0", bus.gnt, 4'b0001);
    bus.bus_ack = 1'b1;
    #1;
    chk("w_done0", bus.done, 4'b0001);
    step();
    bus.bus_ack = 1'b0;
    step();
    chk("w_gnt2b", bus.gnt, 4'b0100);
    chk("w_sel2b", {2'b0, bus.sel}, 4'd2);
    bus.bus_ack = 1'b1;
    step();
    bus.bus_ack = 1'b0;
    bus.req = 4'b0010;
    // master 1 aborts, stray ack later must not produce done
    step();
    chk("ab_gnt1", bus.gnt, 4'b0010);
    step();
    bus.req = 4'b0000;
    #1;
    chk("ab_nodone", bus.done, 4'b0000);
    step();
    chk("ab_release", bus.gnt, 4'b0000);
    bus.bus_ack = 1'b1;
    #1;
    chk("ab_stray", bus.done, 4'b0000);
    step();
    bus.bus_ack = 1'b0;
    chk("ab_stay_idle", bus.gnt, 4'b0000);
    bus.req = 4'b1111;
    step();
    chk("ab_next2", bus.gnt, 4'b0100);
    step();
    // asynchronous reset mid-BUSY
    rstn = 1'b0;
    #1;
    chk("ar_gnt", bus.gnt, 4'b0000);
    chk("ar_busreq", {3'b0, bus.bus_req}, 4'd0);
    chk("ar_done", bus.done, 4'b0000);
    bus.req = 4'b0110;
    step();
    rstn = 1'b1;
    step();
    chk("ar_gnt1", bus.gnt, 4'b0010);
    chk("ar_sel1", {2'b0, bus.sel}, 4'd1);
    bus.bus_ack = 1'b1;
    step();
    bus.bus_ack = 1'b0;
    bus.req = 4'b1000;
    // ack and abort together still complete
    step();
    chk("aa_gnt3", bus.gnt, 4'b1000);
    bus.req = 4'b0000;
    bus.bus_ack = 1'b1;
    #1;
    chk("aa_done", bus.done, 4'b1000);
    step();
    bus.bus_ack = 1'b0;
    chk("aa_release", bus.gnt, 4'b0000);
`ifdef ARB_TIMEOUT_EN
    bus.req = 4'b0001;
    step();
    chk("to_gnt", bus.gnt, 4'b0001);
    for (int c = 1; c < 4; c++) begin
      step();
      chk("to_busreq", {3'b0, bus.bus_req}, 4'd1);
      chk("to_tmo0", {3'b0, bus.timeout}, 4'd0);
    end
    step();
    bus.req = 4'b0000;
    chk("to_gnt0", bus.gnt, 4'b0000);
    chk("to_pulse", {3'b0, bus.timeout}, 4'd1);
    step();
    chk("to_pulse_end", {3'b0, bus.timeout}, 4'd0);
    bus.req = 4'b0001;
    step();
    chk("tk_gnt", bus.gnt, 4'b0001);
    step();
    step();
    step();
    bus.bus_ack = 1'b1;
    #1;
    chk("tk_done", bus.done, 4'b0001);
    step();
    bus.bus_ack = 1'b0;
    bus.req = 4'b0000;
    chk("tk_gnt0", bus.gnt, 4'b0000);
    chk("tk_tmo", {3'b0, bus.timeout}, 4'd0);
`else
    bus.req = 4'b0001;
    step();
    for (int c = 0; c < 20; c++) step();
    chk("nt_hold", bus.gnt, 4'b0001);
    chk("nt_tmo", {3'b0, bus.timeout}, 4'd0);
    bus.bus_ack = 1'b1;
    step();
    bus.bus_ack = 1'b0;
    bus.req = 4'b0000;
    chk("nt_release", bus.gnt, 4'b0000);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bus_arbiter4.md
Name: bus_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one downstream bus or memory port among four masters.
- Drives the 2-bit select of the external 4:1 data/address mux (MUX4) and a one-hot grant.
- Holds the grant until the slave acknowledges the transfer, then returns to idle.
- Sits between the CPU masters (e.g. IF, MEM, DMA, debug) and the shared data memory.

Parameters:
- TIMEOUT, 16: maximum BUSY cycles without bus_ack before abort (used only with ARB_TIMEOUT_EN); legal range 2..255.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- req  input  4  level request per master; held high until done[i] or deliberately dropped.
- bus_ack  input  1  slave completion strobe, one cycle, sampled in BUSY only.
- gnt  output  4  one-hot grant, registered.
- sel  output  2  binary index of the granted master, registered; drives MUX4 select.
- bus_req  output  1  transfer-valid to slave; high exactly while in BUSY.
- done  output  4  combinational completion pulse: gnt & {4{bus_ack}} while in BUSY.
- timeout  output  1  one-cycle abort pulse, registered (constant 0 without ARB_TIMEOUT_EN).

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, gnt=0, sel=0, bus_req=0, timeout=0, cnt=0, last=3 so master 0 has first priority. Reset mid-transfer drops the grant immediately with no done.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first asserted req[i], scanning i = last+1, last+2, ... modulo 4 (wrap from 3 to 0).
  - At the next edge: gnt=one-hot(i), sel=i, state=BUSY, cnt=0.
- State BUSY, bus_req=1. Conditions are evaluated in this priority order:
  1. bus_ack=1: done[sel] pulses combinationally this cycle. Next edge: state=IDLE, gnt=0, last=sel. sel holds its value until the next grant.
  2. req[sel]=0 with no ack (master abort): next edge: state=IDLE, gnt=0, last=sel, no done. A bus_ack arriving in a later IDLE cycle is ignored.
  3. Otherwise stay in BUSY, cnt=cnt+1 (saturating).
- Latency:
  - req rise to gnt/bus_req is 1 cycle.
  - bus_ack to gnt low is 1 cycle.
  - Minimum grant-to-grant spacing is 2 cycles; there is always one IDLE cycle.
- Masters must drop req in the cycle after done. If a master keeps req high, it re-requests and is served again only after the other requesters (round-robin fairness).
- Changes to req[j] for j != sel during BUSY have no effect on the current grant.
- The bus_ack and master-abort case in the same cycle counts as completion: done pulses.
- gnt is always one-hot or zero; sel==index(gnt) whenever gnt!=0.
- All outputs are glitch-free registers except done.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In BUSY, when cnt reaches TIMEOUT-1 with no bus_ack, the next edge sets state=IDLE, gnt=0, last=sel, and pulses timeout=1 for exactly one cycle; no done.
  - bus_ack in that same final cycle wins: normal completion, no timeout.
- Undefined: cnt and the comparison logic are not built; timeout is tied to 0 and a grant may wait indefinitely.

Test Plan:
- Reset release with req=4'b0000, then req=4'b0001 at cycle 0 -> gnt=4'b0001, sel=0, bus_req=1 at cycle 1; bus_ack at cycle 3 -> done=4'b0001 in cycle 3, gnt=0 in cycle 4.
- req=4'b1111 held, bus_ack 1 cycle after each grant, each master drops req after its done -> grant order 0,1,2,3, each grant 3 cycles apart.
- last=2, req=4'b0101 -> master 0 granted (wrap past 3); then with req=4'b0101 re-asserted -> master 2 granted.
- Granted master 1 drops req in BUSY with no ack -> gnt=0 next cycle, done stays 0, a later stray bus_ack produces no done; next grant goes to masters 2/3/0 before master 1.
- rstn pulled low mid-BUSY with gnt=4'b0100 -> gnt=0, bus_req=0 immediately (asynchronous); after release, req=4'b0110 -> master 1 granted first.
- ARB_TIMEOUT_EN, TIMEOUT=4, no bus_ack -> bus_req high for 4 cycles, then gnt=0 and timeout=1 for one cycle. Same setup with bus_ack in the 4th BUSY cycle -> done pulses, timeout stays 0.
